// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: CPOL/CPHA modes, programmable divider and character length,
// registered sample/shift strobes, self-terminating transfer, abort. SPI_CS_DELAY_EN adds cs_n with setup/hold.
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int LEN_WIDTH = 5,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic [LEN_WIDTH-1:0] char_len,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 go,
  input  logic                 stop,
  output logic                 sclk,
  output logic                 sample_stb,
  output logic                 shift_stb,
  output logic                 busy,
  output logic                 done
`ifdef SPI_CS_DELAY_EN
  ,
  output logic                 cs_n
`endif
);

  // Edge counter must reach 2*2^LEN_WIDTH; the shared counter also times CS setup/hold.
  localparam int EDGE_W = LEN_WIDTH + 2;
  localparam int CS_W   = $clog2(CS_SETUP + CS_HOLD + 1);
  localparam int CNT_W  = (DIV_WIDTH > CS_W) ? DIV_WIDTH : CS_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
`ifdef SPI_CS_DELAY_EN
    ,
    S_SETUP,
    S_HOLD
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [EDGE_W-1:0]    edge_q, edge_d, total_q, total_d;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d;
  logic                 sclk_q, sclk_d, sample_q, sample_d, shift_q, shift_d, done_q, done_d;
`ifdef SPI_CS_DELAY_EN
  logic                 cs_n_q, cs_n_d;
`endif

  logic                 step_en, do_abort, do_finish;
  logic [CNT_W-1:0]     step_cnt;
  logic [EDGE_W-1:0]    step_edge, next_edge;

  function automatic logic [DIV_WIDTH-1:0] half_of(input logic [DIV_WIDTH-1:0] div);
    logic [DIV_WIDTH-1:0] h;
    h = div >> 1;
    return (h == '0) ? DIV_WIDTH'(1) : h;
  endfunction

  function automatic logic [EDGE_W-1:0] edges_of(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] n;
    n = (len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len};
    return {n, 1'b0};
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    edge_d    = edge_q;
    total_d   = total_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    done_d    = 1'b0;
`ifdef SPI_CS_DELAY_EN
    cs_n_d    = cs_n_q;
`endif
    step_en   = 1'b0;
    do_abort  = 1'b0;
    do_finish = 1'b0;
    step_cnt  = cnt_q;
    step_edge = edge_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (go && !stop) begin
          half_d    = half_of(divider);
          total_d   = edges_of(char_len);
          cpol_d    = cpol;
          cpha_d    = cpha;
          edge_d    = '0;
          step_edge = '0;
          step_cnt  = CNT_W'(half_d) - CNT_W'(1);
`ifdef SPI_CS_DELAY_EN
          cs_n_d = 1'b0;
          if (CS_SETUP > 0) begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(CS_SETUP - 1);
          end else begin
            state_d = S_RUN;
            step_en = 1'b1;
          end
`else
          state_d = S_RUN;
          step_en = 1'b1;
`endif
        end
      end
`ifdef SPI_CS_DELAY_EN
      S_SETUP: begin
        if (stop) begin
          do_abort = 1'b1;
        end else if (cnt_q == '0) begin
          state_d  = S_RUN;
          step_en  = 1'b1;
          step_cnt = CNT_W'(half_q) - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (stop)              do_abort  = 1'b1;
        else if (cnt_q == '0)  do_finish = 1'b1;
        else                   cnt_d     = cnt_q - CNT_W'(1);
      end
`endif
      S_RUN: begin
        if (stop) begin
          do_abort = 1'b1;
        end else if (edge_q == total_q) begin
`ifdef SPI_CS_DELAY_EN
          if (CS_HOLD > 1) begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(CS_HOLD - 2);
          end else begin
            do_finish = 1'b1;
          end
`else
          do_finish = 1'b1;
`endif
        end else begin
          step_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One half-period tick; sclk is derived from edge parity so it cannot drift from cpol.
    next_edge = step_edge + EDGE_W'(1);
    if (step_en) begin
      if (step_cnt == '0) begin
        edge_d = next_edge;
        cnt_d  = CNT_W'(half_d) - CNT_W'(1);
        sclk_d = cpol_d ^ next_edge[0];
        if (cpha_d) begin
          shift_d  = next_edge[0];
          sample_d = ~next_edge[0];
        end else begin
          sample_d = next_edge[0];
          shift_d  = ~next_edge[0] && (next_edge != total_d);
        end
      end else begin
        cnt_d = step_cnt - CNT_W'(1);
      end
    end

    if (do_abort || do_finish) begin
      state_d = S_IDLE;
      sclk_d  = cpol_q;
      done_d  = do_finish;
`ifdef SPI_CS_DELAY_EN
      cs_n_d  = 1'b1;
`endif
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= DIV_WIDTH'(1);
      edge_q   <= '0;
      total_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SPI_CS_DELAY_EN
      cs_n_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      edge_q   <= edge_d;
      total_q  <= total_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
`ifdef SPI_CS_DELAY_EN
      cs_n_q   <= cs_n_d;
`endif
    end
  end

  assign sclk       = sclk_q;
  assign sample_stb = sample_q;
  assign shift_stb  = shift_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
`ifdef SPI_CS_DELAY_EN
  assign cs_n       = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: per-cycle comparison against an arithmetic schedule model,
// directed mode/boundary transfers with hand-computed tallies, then randomized traffic.
module tb_spi_sclk_gen;
  localparam int LEN_WIDTH = 5;
`ifdef SPI_CS_DELAY_EN
  localparam int SU = 2;  // setup cycles before edge 1
  localparam int HO = 1;  // extra cycles between last edge and done beyond the base one
`else
  localparam int SU = 0;
  localparam int HO = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] divider = '0;
  logic [4:0] char_len = '0;
  logic       cpol = 1'b1, cpha = 1'b0, go = 1'b0, stop = 1'b0;
  logic       sclk, sample_stb, shift_stb, busy, done;
`ifdef SPI_CS_DELAY_EN
  logic       cs_n;
`endif

  int vectors = 0, miscompares = 0;

  // Model state: a transfer accepted at the end of cycle t0 with half-period h and e2 edges.
  int cyc = 0, t0 = 0, h = 1, e2 = 2;
  bit act = 0, done_pend = 0, idle_sclk = 0, m_cpol = 0, m_cpha = 0;
  int n_samp = 0, n_shift = 0, n_busy = 0, n_done = 0, done_off = 0;

  spi_sclk_gen #(.DIV_WIDTH(8), .LEN_WIDTH(LEN_WIDTH), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .divider(divider), .char_len(char_len),
    .cpol(cpol), .cpha(cpha), .go(go), .stop(stop),
    .sclk(sclk), .sample_stb(sample_stb), .shift_stb(shift_stb), .busy(busy), .done(done)
`ifdef SPI_CS_DELAY_EN
    , .cs_n(cs_n)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model advance at each rising edge, from the inputs held during the ending cycle.
  always @(posedge sys_clk) begin
    if (!rst_n) begin
      act = 0; done_pend = 0; idle_sclk = 0;
    end else begin
      done_pend = 0;
      if (act) begin
        if (stop) begin
          act = 0; idle_sclk = m_cpol;
        end else if (cyc - t0 == SU + h * e2 + HO) begin
          act = 0; done_pend = 1; idle_sclk = m_cpol;
        end
      end else if (go && !stop) begin
        act = 1; t0 = cyc;
        h  = ((divider >> 1) == '0) ? 1 : int'(divider >> 1);
        e2 = 2 * ((char_len == '0) ? (1 << LEN_WIDTH) : int'(char_len));
        m_cpol = cpol; m_cpha = cpha;
      end else begin
        idle_sclk = cpol;
      end
    end
    cyc++;
  end

  // Compare every cycle on the falling edge.
  always @(negedge sys_clk) begin
    logic e_sclk, e_samp, e_shift, e_busy, e_done;
    int d, k;
    e_sclk = 0; e_samp = 0; e_shift = 0; e_busy = 0; e_done = 0;
    if (rst_n) begin
      if (act) begin
        e_busy = 1; e_sclk = m_cpol;
        d = cyc - t0 - SU;
        if (d >= 1 && d <= h * e2) begin
          k = d / h;
          e_sclk = m_cpol ^ k[0];
          if (d % h == 0) begin
            if (m_cpha) begin e_shift = k[0]; e_samp = !k[0]; end
            else begin e_samp = k[0]; e_shift = !k[0] && (k != e2); end
          end
        end
      end else begin
        e_sclk = idle_sclk; e_done = done_pend;
      end
    end
    check("outputs{sclk,smp,shf,busy,done}", 32'({sclk, sample_stb, shift_stb, busy, done}),
          32'({e_sclk, e_samp, e_shift, e_busy, e_done}));
`ifdef SPI_CS_DELAY_EN
    check("cs_n", 32'(cs_n), 32'(!e_busy));
`endif
    n_samp  += int'(sample_stb);
    n_shift += int'(shift_stb);
    n_busy  += int'(busy);
    if (done === 1'b1) begin n_done++; done_off = cyc - t0; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_tally();
    n_samp = 0; n_shift = 0; n_busy = 0; n_done = 0; done_off = 0;
  endtask

  task automatic start(input logic [7:0] div, input logic [4:0] len, input logic pol, input logic pha);
    @(negedge sys_clk);
    divider = div; char_len = len; cpol = pol; cpha = pha; go = 1'b1;
    @(negedge sys_clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) seen = 1;
    end
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with cpol=1: sclk must stay 0, then follow cpol after release.
    tick(2);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick(2);
    check("idle_follows_cpol", 32'(sclk), 32'd1);
    cpol = 1'b0;
    tick(2);

    // Mode 0, divider 8, 8 bits.
    clear_tally();
    start(8'd8, 5'd8, 1'b0, 1'b0);
    wait_done(200);
    tick(1);
    check("m0_samples", n_samp, 8);
    check("m0_shifts", n_shift, 7);
    check("m0_busy_cycles", n_busy, 64 + SU + HO);
    check("m0_done_offset", done_off, 65 + SU + HO);
    check("m0_done_count", n_done, 1);

    // Mode 3, divider 2, 4 bits.
    cpol = 1'b1;
    tick(2);
    check("m3_idle_sclk", 32'(sclk), 32'd1);
    clear_tally();
    start(8'd2, 5'd4, 1'b1, 1'b1);
    wait_done(100);
    tick(1);
    check("m3_shifts", n_shift, 4);
    check("m3_samples", n_samp, 4);
    check("m3_busy_cycles", n_busy, 8 + SU + HO);
    check("m3_done_offset", done_off, 9 + SU + HO);
    check("m3_end_sclk", 32'(sclk), 32'd1);

    // char_len=0 -> 32 bits; divider=0 -> HALF=1.
    cpol = 1'b0;
    tick(2);
    clear_tally();
    start(8'd0, 5'd0, 1'b0, 1'b0);
    wait_done(200);
    tick(1);
    check("len0_samples", n_samp, 32);
    check("len0_shifts", n_shift, 31);
    check("len0_done_offset", done_off, 65 + SU + HO);

    // Abort right after edge 5, then restart.
    tick(2);
    clear_tally();
    start(8'd8, 5'd8, 1'b0, 1'b0);
    tick(19 + SU);
    check("stop_edge5_sclk", 32'(sclk), 32'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sclk", 32'(sclk), 32'd0);
    tick(1);
    check("stop_samples", n_samp, 3);
    check("stop_shifts", n_shift, 2);
    tick(3);
    check("stop_no_done", n_done, 0);
    clear_tally();
    start(8'd8, 5'd8, 1'b0, 1'b0);
    wait_done(200);
    tick(1);
    check("restart_samples", n_samp, 8);
    check("restart_done_count", n_done, 1);

    // go and stop together while idle: nothing starts.
    tick(2);
    @(negedge sys_clk);
    go = 1'b1; stop = 1'b1;
    tick(1);
    go = 1'b0; stop = 1'b0;
    check("go_stop_idle_busy", 32'(busy), 32'd0);

    // Second go and config changes while busy are ignored.
    tick(2);
    clear_tally();
    start(8'd8, 5'd8, 1'b0, 1'b0);
    tick(9);
    divider = 8'd4; char_len = 5'd3; go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_done(200);
    tick(1);
    check("busy_go_done_count", n_done, 1);
    check("busy_go_busy_cycles", n_busy, 64 + SU + HO);
    check("busy_go_done_offset", done_off, 65 + SU + HO);

    // Asynchronous reset mid-transfer.
    tick(2);
    start(8'd8, 5'd8, 1'b0, 1'b0);
    tick(13 + SU);
    check("pre_reset_sclk", 32'(sclk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_sclk", 32'(sclk), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(2);
    clear_tally();
    start(8'd8, 5'd8, 1'b0, 1'b0);
    wait_done(200);
    tick(1);
    check("post_reset_done_offset", done_off, 65 + SU + HO);
    check("post_reset_done_count", n_done, 1);

    // Randomized traffic with mid-transfer perturbations, go while busy and aborts.
    for (int it = 0; it < 40; it++) begin
      int limit;
      limit = int'($urandom_range(20, 500));
      @(negedge sys_clk);
      cpol = 1'($urandom);
      tick(1);
      divider = 8'($urandom_range(0, 11));
      char_len = 5'($urandom);
      cpha = 1'($urandom);
      go = 1'b1;
      for (int c = 0; c < limit; c++) begin
        @(negedge sys_clk);
        go   = ($urandom_range(0, 49) == 0);
        stop = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 19) == 0) divider = 8'($urandom_range(0, 11));
        if ($urandom_range(0, 19) == 0) char_len = 5'($urandom);
        if ($urandom_range(0, 19) == 0) cpha = 1'($urandom);
      end
      go = 1'b0; stop = 1'b0;
      for (int w = 0; w < 1200 && (act || done_pend); w++) @(negedge sys_clk);
      if (act || done_pend) check("random_drain", 32'(act), 32'd0);
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
